fetch_fifo: RTL and testbench
=============================

# fetch_fifo

Instruction buffer between `if_stage` and the decode stage. It stores fetched instruction words together with their PC. It decouples memory-response timing from decode stalls, supplies `pc + 4` for JAL/JALR link writes, and drops all buffered words in one cycle when a branch or jump redirects fetch. When nothing is valid, it presents a canonical NOP to decode.

## Interface
Parameters:
- `WORD_WIDTH`, 32: instruction and PC width.
- `DEPTH`, 4: number of entries. Must be a power of two, at least 2.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous reset, active-high. Sampled on the rising edge of `clk`.
- `in_valid_i`  input  1  fetch presents a valid word this cycle.
- `in_instr_i`  input  WORD_WIDTH  fetched instruction (from `instr_rdata_i`).
- `in_pc_i`  input  WORD_WIDTH  address the word was fetched from.
- `in_ready_o`  output  1  buffer can accept a word this cycle.
- `flush_i`  input  1  redirect; discard every stored and incoming word.
- `out_valid_o`  output  1  head entry is valid.
- `out_instr_o`  output  WORD_WIDTH  head instruction, or NOP `32'h0000_0013` when not valid.
- `out_pc_o`  output  WORD_WIDTH  head PC, or 0 when not valid.
- `out_pc_plus4_o`  output  WORD_WIDTH  `out_pc_o + 4`, modulo 2^WORD_WIDTH.
- `out_ready_i`  input  1  decode consumes the head this cycle.
- `count_o`  output  $clog2(DEPTH)+1  number of stored entries.

## Operation
- Storage is a circular buffer with read pointer `rd_ptr` and write pointer `wr_ptr`, each $clog2(DEPTH) bits wide, and a separate occupancy counter `count`.
- Pointers wrap from DEPTH-1 to 0 naturally.
- Push condition: `in_valid_i && in_ready_o && !flush_i`.
  - The push writes `{in_instr_i, in_pc_i}` at `wr_ptr`.
  - `wr_ptr` then increments.
- Pop condition: `out_valid_o && out_ready_i && !flush_i`.
  - `rd_ptr` increments.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when a push and a pop occur together, or when neither occurs.
- `in_ready_o = (count != DEPTH) || out_ready_i`.
  - A push into a full buffer is accepted only when a pop happens in the same cycle.
  - When that happens, `count` stays at DEPTH.
- Without bypass, `out_valid_o = (count != 0)`.
- Flush:
  - On `flush_i`, `rd_ptr`, `wr_ptr` and `count` go to 0 at the next edge.
  - A push and a pop requested in the same cycle are both ignored.
  - Flush has priority over everything except `rst`.
- Reset (`rst`):
  - Pointers and `count` go to 0.
  - Outputs then read: `out_valid_o` = 0, `out_instr_o` = NOP, `out_pc_o` = 0, `out_pc_plus4_o` = 4, `count_o` = 0, `in_ready_o` = 1.
  - Reset mid-operation discards all contents, like a flush.
  - Storage RAM contents need no reset.
- Boundary conditions:
  - A pop while empty has no effect.
  - `in_valid_i` while full with `out_ready_i` = 0 is not accepted; the upstream stage holds the word.

## Timing
- Without bypass, push-to-output latency is 1 cycle: a word pushed at edge N is visible on `out_*` after edge N.
- Pop-to-next-head latency is 1 cycle.
- Throughput is 1 word per cycle sustained, including when full with a simultaneous push and pop.
- `out_*` are driven from storage plus the pointer, with no combinational path from `in_*`; the exception is bypass mode.
- `in_ready_o` has a combinational path from `out_ready_i` only.
- Flush takes effect at the next edge: `out_valid_o` = 0 in the cycle after `flush_i` is asserted.

## Configuration
- Macro: `FETCH_FIFO_BYPASS_EN`.
- When defined, the buffer becomes first-word fall-through:
  - When `count == 0` and `in_valid_i && !flush_i`, `out_*` present `in_*` combinationally and `out_valid_o` = 1 in the same cycle.
  - If `out_ready_i` is also 1, the word is consumed and not stored; `count` stays 0.
  - If `out_ready_i` is 0, the word is stored normally.
- When undefined, there is no path from `in_*` to `out_*`, and latency is 1 cycle as described above.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid_i` = 1 -> `out_valid_o` = 0, `out_instr_o` = `32'h00000013`, `out_pc_plus4_o` = 4, `count_o` = 0.
- Fill and drain, DEPTH = 4, `out_ready_i` = 0:
  - Push PCs 0x100, 0x104, 0x108, 0x10C -> `count_o` = 4 and `in_ready_o` = 0.
  - Then set `out_ready_i` = 1 -> heads appear in order 0x100..0x10C, and `out_pc_plus4_o` = 0x104 on the first.
- Full with simultaneous push and pop:
  - Push 0x110 with `out_ready_i` = 1 -> accepted, `count_o` stays 4.
  - Pointers wrap and the order is preserved through 0x110.
- Flush with concurrent push: 3 entries stored, then `flush_i` = 1 with `in_valid_i` = 1 -> next cycle `count_o` = 0, `out_valid_o` = 0, and the pushed word is lost.
- Wrap-around arithmetic: push PC `32'hFFFF_FFFC` -> `out_pc_plus4_o` = 0.
- With `FETCH_FIFO_BYPASS_EN`: empty buffer, `in_valid_i` = 1, `in_pc_i` = 0x200, `out_ready_i` = 1 -> `out_valid_o` = 1 and `out_pc_o` = 0x200 in the same cycle, with `count_o` staying 0.

Source files
------------

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Instruction/PC buffer between fetch and decode. It supplies
//            pc+4 and a NOP when empty, and flushes in one cycle on a
//            redirect. Optional first-word fall-through under the macro
//            FETCH_FIFO_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid_i,
    input  logic [WORD_WIDTH-1:0]        in_instr_i,
    input  logic [WORD_WIDTH-1:0]        in_pc_i,
    output logic                         in_ready_o,
    input  logic                         flush_i,
    output logic                         out_valid_o,
    output logic [WORD_WIDTH-1:0]        out_instr_o,
    output logic [WORD_WIDTH-1:0]        out_pc_o,
    output logic [WORD_WIDTH-1:0]        out_pc_plus4_o,
    input  logic                         out_ready_i,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WORD_WIDTH-1:0] c_nop  = WORD_WIDTH'(32'h0000_0013);
    localparam logic [CNT_W-1:0]      c_full = CNT_W'(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("fetch_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [2*WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [2*WORD_WIDTH-1:0] head;
    logic                    empty;
    logic                    full;
    logic                    bypass;
    logic                    push;
    logic                    pop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == c_full);
        head  = mem_q[rd_ptr_q];

        // Full buffer still accepts a word when decode drains the head this cycle.
        in_ready_o = !full || out_ready_i;

`ifdef FETCH_FIFO_BYPASS_EN
        bypass = empty && in_valid_i && !flush_i;
`else
        bypass = 1'b0;
`endif

        out_valid_o = !empty || bypass;

        // A bypassed word consumed in the same cycle never touches storage.
        pop  = out_ready_i && !flush_i && !empty;
        push = in_valid_i && in_ready_o && !flush_i && !(bypass && out_ready_i);

        if (bypass) begin
            out_instr_o = in_instr_i;
            out_pc_o    = in_pc_i;
        end else if (!empty) begin
            out_instr_o = head[2*WORD_WIDTH-1:WORD_WIDTH];
            out_pc_o    = head[WORD_WIDTH-1:0];
        end else begin
            out_instr_o = c_nop;
            out_pc_o    = '0;
        end
        out_pc_plus4_o = out_pc_o + WORD_WIDTH'(4);
        count_o        = count_q;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_instr_i, in_pc_i};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_fifo
// Brief    : Self-checking bench for fetch_fifo using a queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_fifo;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;
    localparam logic [W-1:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid_i = 1'b0;
    logic [W-1:0]  in_instr_i = '0;
    logic [W-1:0]  in_pc_i = '0;
    logic          in_ready_o;
    logic          flush_i = 1'b0;
    logic          out_valid_o;
    logic [W-1:0]  out_instr_o;
    logic [W-1:0]  out_pc_o;
    logic [W-1:0]  out_pc_plus4_o;
    logic          out_ready_i = 1'b0;
    logic [CW-1:0] count_o;

    always #5 clk = ~clk;

    fetch_fifo #(.WORD_WIDTH(W), .DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid_i),
        .in_instr_i     (in_instr_i),
        .in_pc_i        (in_pc_i),
        .in_ready_o     (in_ready_o),
        .flush_i        (flush_i),
        .out_valid_o    (out_valid_o),
        .out_instr_o    (out_instr_o),
        .out_pc_o       (out_pc_o),
        .out_pc_plus4_o (out_pc_plus4_o),
        .out_ready_i    (out_ready_i),
        .count_o        (count_o)
    );

    logic [2*W-1:0] model_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input logic r, input logic iv, input logic [W-1:0] ii,
                        input logic [W-1:0] ip, input logic ordy, input logic fl);
        logic         byp;
        logic         ev;
        logic         er;
        logic [W-1:0] ei;
        logic [W-1:0] ep;
        @(negedge clk);
        rst = r; in_valid_i = iv; in_instr_i = ii; in_pc_i = ip;
        out_ready_i = ordy; flush_i = fl;
        #1;
        byp = 1'b0;
`ifdef FETCH_FIFO_BYPASS_EN
        byp = (model_q.size() == 0) && iv && !fl;
`endif
        ev = (model_q.size() != 0) || byp;
        er = (model_q.size() != D) || ordy;
        if (model_q.size() != 0) begin
            ei = model_q[0][2*W-1:W];
            ep = model_q[0][W-1:0];
        end else if (byp) begin
            ei = ii;
            ep = ip;
        end else begin
            ei = NOP;
            ep = '0;
        end
        check("out_valid", 64'(out_valid_o), 64'(ev));
        check("out_instr", 64'(out_instr_o), 64'(ei));
        check("out_pc", 64'(out_pc_o), 64'(ep));
        check("out_pc_plus4", 64'(out_pc_plus4_o), 64'(W'(ep + 32'd4)));
        check("count", 64'(count_o), 64'(model_q.size()));
        check("in_ready", 64'(in_ready_o), 64'(er));
        if (r || fl) begin
            model_q.delete();
        end else if (!(byp && ordy)) begin
            if (ordy && model_q.size() != 0) void'(model_q.pop_front());
            if (iv && er) model_q.push_back({ii, ip});
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, '0, '0, ordy, 1'b0);
    endtask

    task automatic push(input logic [W-1:0] pc, input logic ordy);
        step(1'b0, 1'b1, pc ^ 32'hA5A5_0000, pc, ordy, 1'b0);
    endtask

    initial begin
        // Reset with in_valid held high
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h40, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h40, 1'b0, 1'b0);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_instr", 64'(out_instr_o), 64'h13);
        check("rst_pc", 64'(out_pc_o), 64'd0);
        check("rst_plus4", 64'(out_pc_plus4_o), 64'd4);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_ready", 64'(in_ready_o), 64'd1);

        // Fill, reject while full, drain in order
        push(32'h100, 1'b0);
        push(32'h104, 1'b0);
        push(32'h108, 1'b0);
        push(32'h10C, 1'b0);
        push(32'h200, 1'b0);
        check("full_count", 64'(count_o), 64'd4);
        check("full_ready", 64'(in_ready_o), 64'd0);
        check("full_head", 64'(out_pc_o), 64'h100);
        check("full_plus4", 64'(out_pc_plus4_o), 64'h104);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);
        check("drained_valid", 64'(out_valid_o), 64'd0);

        // Full with simultaneous push and pop, pointers wrap
        push(32'h100, 1'b0);
        push(32'h104, 1'b0);
        push(32'h108, 1'b0);
        push(32'h10C, 1'b0);
        push(32'h110, 1'b1);
        check("pp_ready", 64'(in_ready_o), 64'd1);
        idle(1'b0);
        check("pp_count", 64'(count_o), 64'd4);
        check("pp_head", 64'(out_pc_o), 64'h104);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);

        // Flush with concurrent push
        push(32'h300, 1'b0);
        push(32'h304, 1'b0);
        push(32'h308, 1'b0);
        step(1'b0, 1'b1, 32'h1111_1111, 32'h30C, 1'b0, 1'b1);
        idle(1'b0);
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_valid", 64'(out_valid_o), 64'd0);

        // pc+4 wrap-around
        push(32'hFFFF_FFFC, 1'b0);
        idle(1'b0);
        check("wrap_pc", 64'(out_pc_o), 64'hFFFF_FFFC);
        check("wrap_plus4", 64'(out_pc_plus4_o), 64'd0);
        idle(1'b1);

`ifdef FETCH_FIFO_BYPASS_EN
        idle(1'b0);
        push(32'h200, 1'b1);
        check("byp_valid", 64'(out_valid_o), 64'd1);
        check("byp_pc", 64'(out_pc_o), 64'h200);
        check("byp_count", 64'(count_o), 64'd0);
        idle(1'b0);
        check("byp_count_after", 64'(count_o), 64'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 W'($urandom), W'($urandom) & ~32'h3,
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
